// File: rtl/console_uart_pkg.sv
// Shared types and register map for the console UART transmitter.
package console_uart_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   localparam logic [31:0] DATA_OFS = 32'd0;
   localparam logic [31:0] STAT_OFS = 32'd4;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_EMPTY     = 2;
   localparam int STAT_COUNT_LSB = 8;

   function automatic logic [31:0] status_word(input logic       busy,
                                               input logic       full,
                                               input logic       empty,
                                               input logic [7:0] count);
      logic [31:0] w;
      w                       = '0;
      w[STAT_BUSY]            = busy;
      w[STAT_FULL]            = full;
      w[STAT_EMPTY]           = empty;
      w[STAT_COUNT_LSB +: 8]  = count;
      return w;
   endfunction

endpackage

// File: rtl/console_fifo.sv
// Circular synchronous FIFO with separate occupancy count; head is visible combinationally.
module console_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; pointers and count alone define valid entries.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/console_uart_tx.sv
// Memory-mapped console: byte writes to the data register are queued and sent as 8N1 frames on txd.
module console_uart_tx
   import console_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   input  logic [3:0]  mem_rmask,
   output logic        sel,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        txd,
   output logic        busy
);

   localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
   localparam int          BW          = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
   localparam logic [31:0] DATA_ADDR   = BASE_ADDR + DATA_OFS;
   localparam logic [31:0] STAT_ADDR   = BASE_ADDR + STAT_OFS;

   logic          hit_data;
   logic          hit_stat;
   logic          is_write;
   logic          fifo_push;
   logic          fifo_pop;
   logic [7:0]    fifo_rdata;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          unused_bits;

   tx_state_e     state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          txd_q, txd_d;
   logic          busy_q, busy_d;

   // Bus decode: rmask and upper write bytes carry no meaning for this block.
   assign unused_bits = ^{mem_rmask, mem_wdata[31:8]};
   assign hit_data    = (mem_addr == DATA_ADDR);
   assign hit_stat    = (mem_addr == STAT_ADDR);
   assign sel         = mem_valid && (hit_data || hit_stat);
   assign is_write    = |mem_wstrb;
   assign fifo_push   = sel && hit_data && mem_wstrb[0] && !fifo_full;

   always_comb begin
      mem_ready = 1'b0;
      if (sel) mem_ready = (hit_data && mem_wstrb[0]) ? !fifo_full : 1'b1;
   end

   assign mem_rdata = (sel && hit_stat && !is_write)
                    ? status_word(busy_q, fifo_full, fifo_empty, 8'(fifo_count))
                    : 32'd0;

   console_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (fifo_push),
      .wdata  (mem_wdata[7:0]),
      .pop    (fifo_pop),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= TX_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
      end
   end

   // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      fifo_pop  = 1'b0;

      case (state_q)
         TX_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               baud_d   = BAUD_RELOAD;
               state_d  = TX_START;
            end
         end
         TX_START: begin
            if (baud_q == '0) begin
               baud_d    = BAUD_RELOAD;
               bit_idx_d = '0;
               state_d   = TX_DATA;
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         TX_DATA: begin
            if (baud_q == '0) begin
               baud_d  = BAUD_RELOAD;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) state_d = TX_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         TX_STOP: begin
            if (baud_q == '0) begin
               // Chain straight into the next start bit when more data is waiting.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  baud_d   = BAUD_RELOAD;
                  state_d  = TX_START;
               end else begin
                  state_d = TX_IDLE;
               end
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         default: state_d = TX_IDLE;
      endcase

      txd_d = 1'b1;
      case (state_d)
         TX_START: txd_d = 1'b0;
         TX_DATA:  txd_d = shift_d[0];
         default:  txd_d = 1'b1;
      endcase

      busy_d = (state_d != TX_IDLE) || !fifo_empty;
   end

   assign txd  = txd_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed self-checking bench for console_uart_tx with a small bus table and a UART receive monitor.
module tb_console_uart_tx;

   localparam int          CPB    = 4;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] DATA_A = 32'h1000_0000;
   localparam logic [31:0] STAT_A = 32'h1000_0004;
   localparam logic [31:0] BAD_A  = 32'h1000_0008;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic [3:0]  mem_rmask = '0;
   logic        sel;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        txd;
   logic        busy;

   console_uart_tx #(
      .BASE_ADDR    (DATA_A),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rmask (mem_rmask),
      .sel       (sel),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .txd       (txd),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass   = 0;
   int n_checks = 0;

   typedef struct {
      string       name;
      logic        valid;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [3:0]  rmask;
      logic        exp_sel;
      logic        exp_ready;
      logic [31:0] exp_rdata;
   } vec_t;

   // Receive monitor: samples each bit at its centre on falling clock edges.
   logic [7:0] rx_q[$];
   int         rx_start_q[$];
   logic       rx_stop_q[$];
   logic       mon_prev = 1'b1;

   initial begin
      logic [7:0] b;
      int         s;
      forever begin
         @(negedge clk);
         if (resetn && mon_prev && !txd) begin
            s = cyc;
            b = '0;
            repeat (6) @(negedge clk);
            b[0] = txd;
            for (int i = 1; i < 8; i++) begin
               repeat (4) @(negedge clk);
               b[i] = txd;
            end
            repeat (4) @(negedge clk);
            rx_q.push_back(b);
            rx_start_q.push_back(s);
            rx_stop_q.push_back(txd);
         end
         mon_prev = txd;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      else n_pass++;
   endtask

   task automatic clear_rx();
      rx_q.delete();
      rx_start_q.delete();
      rx_stop_q.delete();
   endtask

   // Called on a falling edge; returns on the falling edge after the accepting rising edge.
   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output int stall, output int acc);
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wdata = data;
      mem_wstrb = strb;
      mem_rmask = 4'h0;
      stall     = 0;
      #1;
      while (!mem_ready && stall < 2000) begin
         @(negedge clk);
         #1;
         stall++;
      end
      if (!mem_ready) check("write_ready_timeout", 32'(mem_ready), 32'd1);
      acc = cyc + 1;
      @(posedge clk);
      @(negedge clk);
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic rdy);
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wstrb = 4'h0;
      mem_rmask = 4'hf;
      #1;
      data = mem_rdata;
      rdy  = mem_ready;
      @(posedge clk);
      @(negedge clk);
      mem_valid = 1'b0;
      mem_rmask = 4'h0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("idle_wait", 32'(busy), 32'd0);
   endtask

   task automatic wait_rx(input int n);
      int t = 0;
      while (rx_q.size() < n && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("rx_count", rx_q.size(), n);
   endtask

   function automatic vec_t mk(input string name, input logic valid, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               input logic [3:0] rmask, input logic exp_sel,
                               input logic exp_ready, input logic [31:0] exp_rdata);
      vec_t v;
      v.name = name; v.valid = valid; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
      v.rmask = rmask; v.exp_sel = exp_sel; v.exp_ready = exp_ready; v.exp_rdata = exp_rdata;
      return v;
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[8];
      int          st;
      int          ac;
      int          acc[6];
      int          stl[6];
      int          errs;
      int          polls;
      logic [31:0] d;
      logic        r;
      logic [7:0]  b;
      logic        exp_txd;
      logic        exp_busy;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      resetn = 1'b1;
      bus_read(STAT_A, d, r);
      check("rst_status", d, 32'h0000_0004);

      // Bus decode table, applied with the transmitter idle
      vecs[0] = mk("stat_rd",        1, STAT_A, 0,            4'h0, 4'hf, 1, 1, 32'h0000_0004);
      vecs[1] = mk("stat_rd_nomask", 1, STAT_A, 0,            4'h0, 4'h0, 1, 1, 32'h0000_0004);
      vecs[2] = mk("data_rd",        1, DATA_A, 0,            4'h0, 4'hf, 1, 1, 32'h0);
      vecs[3] = mk("data_wr_b1",     1, DATA_A, 32'h0000_5a00, 4'b0010, 4'h0, 1, 1, 32'h0);
      vecs[4] = mk("stat_wr",        1, STAT_A, 32'hffff_ffff, 4'hf, 4'h0, 1, 1, 32'h0);
      vecs[5] = mk("bad_rd",         1, BAD_A,  0,            4'h0, 4'hf, 0, 0, 32'h0);
      vecs[6] = mk("bad_wr",         1, BAD_A,  32'h41,       4'h1, 4'h0, 0, 0, 32'h0);
      vecs[7] = mk("novalid_wr",     0, DATA_A, 32'h41,       4'h1, 4'h0, 0, 0, 32'h0);
      for (int i = 0; i < 8; i++) begin
         mem_valid = vecs[i].valid;
         mem_addr  = vecs[i].addr;
         mem_wdata = vecs[i].wdata;
         mem_wstrb = vecs[i].wstrb;
         mem_rmask = vecs[i].rmask;
         #1;
         check({vecs[i].name, "_sel"},   32'(sel),       32'(vecs[i].exp_sel));
         check({vecs[i].name, "_ready"}, 32'(mem_ready), 32'(vecs[i].exp_ready));
         check({vecs[i].name, "_rdata"}, mem_rdata,      vecs[i].exp_rdata);
         @(posedge clk);
         @(negedge clk);
         mem_valid = 1'b0;
         mem_wstrb = 4'h0;
         mem_rmask = 4'h0;
      end
      errs = 0;
      repeat (50) begin
         @(negedge clk);
         if (!txd || busy) errs++;
      end
      check("ignored_no_frame", errs, 0);
      bus_read(STAT_A, d, r);
      check("ignored_status", d, 32'h0000_0004);

      // Single frame, checked cycle by cycle
      clear_rx();
      b = 8'h41;
      bus_write(DATA_A, 32'h0000_0041, 4'h1, st, ac);
      check("t1_no_stall", st, 0);
      for (int j = 0; j <= 41; j++) begin
         if (j >= 1 && j <= 4)       exp_txd = 1'b0;
         else if (j >= 5 && j <= 36) exp_txd = b[(j - 5) / 4];
         else                        exp_txd = 1'b1;
         exp_busy = (j >= 1 && j <= 40);
         check($sformatf("t1_txd[%0d]", j),  32'(txd),  32'(exp_txd));
         check($sformatf("t1_busy[%0d]", j), 32'(busy), 32'(exp_busy));
         @(negedge clk);
      end
      check("t1_rx_byte", rx_q.size() > 0 ? 32'(rx_q[0]) : 32'hffff_ffff, 32'h41);

      // Burst of six writes into a four-deep FIFO
      wait_idle();
      clear_rx();
      for (int i = 0; i < 6; i++) begin
         bus_write(DATA_A, 32'(i), 4'h1, st, ac);
         stl[i] = st;
         acc[i] = ac;
      end
      for (int i = 0; i < 5; i++) check($sformatf("t2_stall[%0d]", i), stl[i], 0);
      check("t2_stall_6th", stl[5], 37);
      check("t2_accept_6th", acc[5] - acc[0], 42);
      wait_rx(6);
      if (rx_start_q.size() > 0) check("t2_first_start", rx_start_q[0], acc[0] + 1);
      for (int i = 0; i < rx_q.size(); i++) begin
         check($sformatf("t2_byte[%0d]", i), 32'(rx_q[i]), 32'(i));
         check($sformatf("t2_stop[%0d]", i), 32'(rx_stop_q[i]), 32'd1);
         if (i > 0) check($sformatf("t2_gap[%0d]", i), rx_start_q[i] - rx_start_q[i-1], 40);
      end

      // Status while queued, while full, and after drain
      wait_idle();
      for (int i = 0; i < 4; i++) bus_write(DATA_A, 32'h60 + 32'(i), 4'h1, st, ac);
      bus_read(STAT_A, d, r);
      check("t3_ready", 32'(r), 32'd1);
      check("t3_queued", d, 32'h0000_0301);
      bus_write(DATA_A, 32'h64, 4'h1, st, ac);
      bus_read(STAT_A, d, r);
      check("t3_full", d, 32'h0000_0403);
      wait_idle();
      bus_read(STAT_A, d, r);
      check("t3_drained", d, 32'h0000_0004);

      // Reset during data bit 3 with two bytes queued
      bus_write(DATA_A, 32'h08, 4'h1, st, ac);
      bus_write(DATA_A, 32'h55, 4'h1, st, ac);
      bus_write(DATA_A, 32'haa, 4'h1, st, ac);
      bus_read(STAT_A, d, r);
      check("t5_pre_status", d, 32'h0000_0201);
      repeat (15) @(negedge clk);
      check("t5_bit3", 32'(txd), 32'd1);
      resetn = 1'b0;
      @(negedge clk);
      check("t5_txd_after_rst", 32'(txd), 32'd1);
      check("t5_busy_after_rst", 32'(busy), 32'd0);
      resetn = 1'b1;
      bus_read(STAT_A, d, r);
      check("t5_status", d, 32'h0000_0004);
      errs = 0;
      repeat (100) begin
         @(negedge clk);
         if (!txd || busy) errs++;
      end
      check("t5_no_frames", errs, 0);

      // Ten bytes throttled on the full flag, wrapping the pointers
      clear_rx();
      for (int i = 0; i < 10; i++) begin
         polls = 0;
         do begin
            bus_read(STAT_A, d, r);
            polls++;
         end while (d[1] && polls < 1000);
         bus_write(DATA_A, 32'h30 + 32'(i), 4'h1, st, ac);
      end
      wait_rx(10);
      for (int i = 0; i < rx_q.size(); i++) begin
         check($sformatf("t6_byte[%0d]", i), 32'(rx_q[i]), 32'h30 + 32'(i));
         check($sformatf("t6_stop[%0d]", i), 32'(rx_stop_q[i]), 32'd1);
      end
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
